// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit-instruction, 12-register CPU.
package cpu_pkg;

    localparam int INSTR_W  = 9;
    localparam int NUM_REGS = 12;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_SLL = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } seq_state_t;

endpackage

// File: rtl/pc_next.sv
// Next program counter: signed jump offset, branch skip or sequential step.
module pc_next #(
    parameter int pc_width = 10
) (
    input  logic [pc_width-1:0] pc,
    input  logic                jump,
    input  logic [7:0]          imm,
    input  logic                branch_taken,
    output logic [pc_width-1:0] next_pc
);

    logic [pc_width-1:0] step;

    always_comb begin
        if (jump) begin
            step = {{(pc_width-8){imm[7]}}, imm};
        end else if (branch_taken) begin
            step = pc_width'(2);
        end else begin
            step = pc_width'(1);
        end
    end

    // Truncated add gives the required wrap in both directions.
    assign next_pc = pc + step;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM and program counter: fetch, decode, memory handshake, write-back.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   FETCH  | ROM read of pc
//   DECODE | latch ROM data into instruction register
//   EXEC   | decoder outputs valid; choose HALT, MEM or WB
//   MEM    | data memory request, bounded wait for ack
//   WB     | one-cycle write strobes and pc update
//   HALT   | done instruction reached
//   ERROR  | memory timeout
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int pc_width     = 10,
    parameter int instr_width  = INSTR_W,
    parameter int op_width     = 4,
    parameter int max_mem_wait = 15,
    parameter int cnt_width    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [pc_width-1:0]    start_addr,
    input  logic [instr_width-1:0] instr_in,
    output logic                   fetch_en,
    output logic [pc_width-1:0]    pc,
    output logic [instr_width-1:0] instr_out,
    input  logic [op_width-1:0]    dec_alu_op,
    input  logic                   dec_jump,
    input  logic [7:0]             dec_imm,
    input  logic                   dec_reg_write,
    input  logic                   dec_car_write,
    input  logic                   dec_mem_read,
    input  logic                   dec_mem_write,
    input  logic                   dec_done,
    input  logic                   alu_zero,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic                   reg_write_en,
    output logic                   car_write_en,
    output logic                   busy,
    output logic                   halted,
    output logic                   err,
    output logic [cnt_width-1:0]   cycle_count
);

    localparam int WAIT_W = $clog2(max_mem_wait);

    seq_state_t             state_q, state_d;
    logic [pc_width-1:0]    pc_q, pc_d, pc_nxt;
    logic [instr_width-1:0] instr_q, instr_d;
    logic [cnt_width-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   halted_q, halted_d;
    logic                   err_q, err_d;

    pc_next #(.pc_width(pc_width)) u_pc_next (
        .pc           (pc_q),
        .jump         (dec_jump),
        .imm          (dec_imm),
        .branch_taken (dec_alu_op == op_width'(ALU_BEQ) && alu_zero),
        .next_pc      (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        halted_d = halted_q;
        err_d    = err_q;
        busy     = 1'b0;

        if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            busy = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + cnt_width'(1);
            end
        end

        case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start) begin
                    pc_d     = start_addr;
                    cnt_d    = '0;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                instr_d = instr_in;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec_done) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (dec_mem_read || dec_mem_write) begin
                    wait_d  = WAIT_W'(max_mem_wait - 1);
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Ack wins even on the last permitted wait cycle.
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_WB: begin
                pc_d    = pc_nxt;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fetch_en     = (state_q == S_FETCH);
    assign mem_req      = (state_q == S_MEM);
    assign reg_write_en = (state_q == S_WB) && dec_reg_write && !dec_mem_write;
    assign car_write_en = (state_q == S_WB) && dec_car_write;
    assign pc           = pc_q;
    assign instr_out    = instr_q;
    assign halted       = halted_q;
    assign err          = err_q;
    assign cycle_count  = cnt_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM and program counter for the 9-bit-instruction, 12-register CPU. It fetches from the instruction ROM and holds the instruction register that feeds the instruction decoder. It gates the decoder's write enables into one-cycle pulses and handshakes with data memory for LW/SW. It computes next-PC for jump, BEQ and sequential flow, and halts on the done instruction.

Parameters:
pc_width, 10, program counter / instruction ROM address width
instr_width, 9, instruction width
op_width, 4, decoder alu_op width
max_mem_wait, 15, MEM cycles without ack before error
cnt_width, 16, cycle counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin execution at start_addr
start_addr  in  pc_width  first instruction address
instr_in  in  instr_width  ROM data, valid the cycle after fetch_en
fetch_en  out  1  ROM read enable
pc  out  pc_width  current instruction address
instr_out  out  instr_width  instruction register, to decoder
dec_alu_op  in  op_width  decoder alu_op (7 = BEQ)
dec_jump  in  1  decoder jump
dec_imm  in  8  decoder imm; signed jump offset
dec_reg_write, dec_car_write  in  1  decoder write requests
dec_mem_read, dec_mem_write  in  1  decoder memory requests
dec_done  in  1  decoder done
alu_zero  in  1  ALU equality result for BEQ
mem_req  out  1  data memory request, held until ack
mem_ack  in  1  data memory completion
reg_write_en, car_write_en  out  1  gated one-cycle write strobes
busy  out  1  high in FETCH..WB
halted  out  1  done reached
err  out  1  memory timeout
cycle_count  out  cnt_width  cycles spent busy since start

Behaviour:
- Reset (async, rst_n=0): state IDLE. pc=0, instr_out=0, cycle_count=0, every 1-bit output 0. Reset mid-instruction aborts it; no write strobe is emitted.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE/HALT/ERROR + start=1: pc<=start_addr, cycle_count<=0, halted<=0, err<=0, next FETCH. start is ignored while busy.
- FETCH: fetch_en=1 (addr=pc); next DECODE.
- DECODE: instr_out<=instr_in; next EXEC. Decoder outputs are valid from EXEC onward.
- EXEC: if dec_done then HALT, halted<=1, pc unchanged. Else if dec_mem_read|dec_mem_write then MEM. Else WB.
- MEM: mem_req=1. Transition out of MEM is taken on the cycle the signal is sampled.
  - mem_ack=1: next WB.
  - Ack in the first MEM cycle is legal.
  - Wait counter reaching max_mem_wait with no ack: next ERROR, err<=1, mem_req drops.
  - mem_ack outside MEM is ignored.
- WB, one cycle:
  - reg_write_en = dec_reg_write & ~dec_mem_write. SW never writes the register file.
  - car_write_en = dec_car_write.
  - pc update, priority order:
    - dec_jump: pc <= pc + sign_extend(dec_imm).
    - else dec_alu_op==7 and alu_zero: pc <= pc+2 (skip next instruction).
    - else pc <= pc+1.
  - All pc arithmetic wraps modulo 2^pc_width. A negative offset past 0 wraps high.
  - Next FETCH.
- Latency: non-memory instruction = 4 cycles (FETCH, DECODE, EXEC, WB). LW/SW = 4 + number of MEM cycles.
- busy=1 in FETCH, DECODE, EXEC, MEM, WB.
- cycle_count increments every busy cycle and saturates at all-ones.
- halted and err are sticky until start or reset. Outputs other than strobes hold their values in HALT/ERROR.
- Write strobes and mem_req are never asserted outside WB and MEM respectively.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum seq_state_t;
  - alu op constants (ALU_AND=0 … ALU_BEQ=7, ALU_SRL=8, ALU_SRA=9, ALU_SLL=10);
  - widths INSTR_W=9 and NUM_REGS=12.
- One sub-module, pc_next: purely combinational. Inputs pc, jump, imm, branch_taken; output next pc with the wrap rule.

Test Plan:
- Reset then start, start_addr=0x010, ROM holding an ADD → fetch_en at cycle 1, reg_write_en and car_write_en pulse in cycle 4, pc=0x011, cycle_count=4.
- JR with imm=0xFC (-4) at pc=0x002 → pc=0x3FE (wrap). JR with imm=0x05 at pc=0x3FD → pc=0x002.
- BEQ (alu_op=7) at pc=0x020: alu_zero=1 → pc=0x022; alu_zero=0 → pc=0x021; no reg_write_en in either case.
- LW with mem_ack after 3 MEM cycles → mem_req high exactly 3 cycles, reg_write_en pulses next cycle. SW with immediate ack → mem_req 1 cycle, reg_write_en never asserted.
- mem_ack held 0 for 15 MEM cycles → err=1, mem_req=0, busy=0. A later start clears err and restarts at start_addr.
- Done instruction (0b111xxxx11) → halted=1, pc frozen, start mid-run ignored. rst_n low during MEM → all outputs 0 immediately, no strobe.
